fpga_cfg_loader: RTL
====================

FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 SHALL have parameter HDR_BYTE, default 8'hA5, the stream header byte value.
REQ-002 SHALL have parameter PAYLOAD_BYTES, default 335, payload byte count (2678 config bits + 2 pad bits).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a load; honoured only in IDLE or ERR.
REQ-006 abort  input  1  cancel an in-progress load.
REQ-007 cfg_valid  input  1  cfg_data holds a byte.
REQ-008 cfg_data  input  8  stream byte.
REQ-009 cfg_ready  output  1  loader accepts a byte this cycle.
REQ-010 busy  output  1  high in HDR, LOAD, CHK and COMMIT.
REQ-011 done  output  1  one-cycle pulse on a successful commit.
REQ-012 error  output  1  high while in ERR.
REQ-013 brbselect  output  750  live routing-block configuration.
REQ-014 bsbselect  output  1728  live switch-block configuration.
REQ-015 lbselect  output  80  live logic-block configuration.
REQ-016 leftioselect, rightioselect, topioselect, bottomioselect  output  30 each  live IO configuration.

Function
REQ-017 The block SHALL implement FSM states IDLE, HDR, LOAD, CHK, COMMIT and ERR.
REQ-018 A byte SHALL transfer only on an edge where cfg_valid and cfg_ready are both 1.
REQ-019 cfg_ready SHALL be 1 exactly in HDR, LOAD and CHK, and SHALL not depend combinationally on cfg_valid.
REQ-020 IDLE/ERR with start=1 SHALL go to HDR, clear error, zero the shadow register, byte counter and XOR accumulator.
REQ-021 In HDR, an accepted byte equal to HDR_BYTE SHALL go to LOAD; any other value SHALL go to ERR.
REQ-022 In LOAD, accepted byte k (0..PAYLOAD_BYTES-1), bit j, SHALL write shadow global bit 8k+j.
REQ-022a Pad bits 2678 and 2679 SHALL be discarded.
REQ-023 Global bit order SHALL be brbselect[0..749], bsbselect[0..1727], lbselect[0..79], then leftioselect, rightioselect, topioselect and bottomioselect [0..29] each, starting at global offsets 2558, 2588, 2618 and 2648.
REQ-024 Every payload byte, including the byte carrying the pad bits, SHALL be XORed into the 8-bit accumulator.
REQ-025 Acceptance of byte PAYLOAD_BYTES-1 SHALL move LOAD to CHK.
REQ-026 In CHK, an accepted byte equal to the accumulator SHALL go to COMMIT; a mismatch SHALL go to ERR.
REQ-027 In COMMIT, on the next edge, all live outputs SHALL load the shadow simultaneously, done SHALL register 1, and the state SHALL return to IDLE.
REQ-027a done SHALL be 1 for exactly one cycle, the first cycle in which the new configuration is visible.
REQ-028 Live outputs SHALL change only at a COMMIT edge or on reset; a load ending in ERR or abort SHALL leave them unchanged.
REQ-029 abort=1 in HDR, LOAD or CHK SHALL return to IDLE; any byte presented that edge SHALL not be accepted.
REQ-029a abort SHALL be ignored in COMMIT, IDLE and ERR.
REQ-030 start in HDR, LOAD, CHK or COMMIT SHALL be ignored.
REQ-030a If start and abort are both 1, abort SHALL win.
REQ-031 ERR SHALL persist, with cfg_ready=0, until start or rst.
REQ-032 The byte counter SHALL be 9 bits and SHALL never wrap during a load.

Reset
REQ-033 rst=1 SHALL force, on the next edge: state IDLE, all live and shadow config bits 0, counter 0, accumulator 0, cfg_ready=0, busy=0, done=0, error=0.
REQ-034 rst SHALL override start, abort and any handshake in the same cycle, including mid-load.

Verification
REQ-035 Header 0xA5; 335 bytes all 0x00 except byte 327=0x08 and byte 331=0x01; checksum 0x09 -> done one cycle later, topioselect[1]=1, bottomioselect[0]=1, all other bits 0.
REQ-036 Header 0x5A -> error=1, cfg_ready=0; live outputs unchanged; a following start and a valid stream -> done.
REQ-037 Valid payload with checksum 0x00 instead of 0x09 -> ERR; previously committed configuration retained.
REQ-038 abort after 100 payload bytes -> IDLE, busy=0, no done; a full reload then commits correctly.
REQ-039 cfg_valid toggled randomly (about 50% duty) through a full load -> result identical to REQ-035.
REQ-040 rst asserted at byte 200 -> all outputs 0 the next cycle; cfg_valid ignored until start.

Source files
------------

// File: rtl/fpga_cfg_loader_if.sv
// Byte-stream and status bundle between a configuration source and fpga_cfg_loader.
// The source drives the stream and control inputs. The loader returns the handshake and status.
interface fpga_cfg_loader_if;
  logic       start;
  logic       abort;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output start, abort, cfg_valid, cfg_data,
    input  cfg_ready, busy, done, error
  );

  modport slave (
    input  start, abort, cfg_valid, cfg_data,
    output cfg_ready, busy, done, error
  );
endinterface

// File: rtl/fpga_cfg_loader.sv
// Loads a header + payload + XOR-checksum byte stream into a shadow register.
// The live fabric configuration changes only when a load commits, or on reset.
module fpga_cfg_loader #(
  parameter logic [7:0] HDR_BYTE      = 8'hA5,
  parameter int         PAYLOAD_BYTES = 335
) (
  input  logic                clk,
  input  logic                rst,
  fpga_cfg_loader_if.slave    bus,
  output logic [749:0]        brbselect,
  output logic [1727:0]       bsbselect,
  output logic [79:0]         lbselect,
  output logic [29:0]         leftioselect,
  output logic [29:0]         rightioselect,
  output logic [29:0]         topioselect,
  output logic [29:0]         bottomioselect
);

  localparam int CFG_BITS = 2678;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD, S_CHK, S_COMMIT, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic                cfg_ready_q, busy_q, done_q, error_q;
  logic [8:0]          cnt_q;
  logic [7:0]          acc_q;
  logic [CFG_BITS-1:0] shadow_q, live_q;

  logic                xfer, start_ok, last_byte;
  logic [11:0]         bit_base;

  // An abort on the same edge blocks the transfer, even with a byte on offer.
  assign xfer      = bus.cfg_valid & cfg_ready_q & ~bus.abort;
  assign start_ok  = bus.start & ((state_q == S_IDLE) | (state_q == S_ERR));
  assign last_byte = (cnt_q == 9'(PAYLOAD_BYTES - 1));
  assign bit_base  = {cnt_q, 3'b000};

  // NOTE: every variable in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERR: if (bus.start) state_d = S_HDR;
      S_HDR: begin
        if (bus.abort)  state_d = S_IDLE;
        else if (xfer)  state_d = (bus.cfg_data == HDR_BYTE) ? S_LOAD : S_ERR;
      end
      S_LOAD: begin
        if (bus.abort)              state_d = S_IDLE;
        else if (xfer && last_byte) state_d = S_CHK;
      end
      S_CHK: begin
        if (bus.abort)  state_d = S_IDLE;
        else if (xfer)  state_d = (bus.cfg_data == acc_q) ? S_COMMIT : S_ERR;
      end
      S_COMMIT:         state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state, so they line up with state_q.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_ready_q <= state_d inside {S_HDR, S_LOAD, S_CHK};
      busy_q      <= state_d inside {S_HDR, S_LOAD, S_CHK, S_COMMIT};
      done_q      <= (state_q == S_COMMIT);
      error_q     <= (state_d == S_ERR);
    end
  end

  // NOTE: shadow and live are plain flop arrays, not RAM, so they are cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      live_q   <= '0;
    end else begin
      if (start_ok) begin
        cnt_q    <= '0;
        acc_q    <= '0;
        shadow_q <= '0;
      end else if (xfer && (state_q == S_LOAD)) begin
        cnt_q <= cnt_q + 9'd1;
        acc_q <= acc_q ^ bus.cfg_data;
        // Bits that fall past the last config bit are the pad bits; drop them.
        for (int j = 0; j < 8; j++) begin
          if (bit_base + 12'(j) < 12'(CFG_BITS))
            shadow_q[bit_base + 12'(j)] <= bus.cfg_data[j];
        end
      end
      if (state_q == S_COMMIT) live_q <= shadow_q;
    end
  end

  assign bus.cfg_ready  = cfg_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

  assign brbselect      = live_q[749:0];
  assign bsbselect      = live_q[2477:750];
  assign lbselect       = live_q[2557:2478];
  assign leftioselect   = live_q[2587:2558];
  assign rightioselect  = live_q[2617:2588];
  assign topioselect    = live_q[2647:2618];
  assign bottomioselect = live_q[2677:2648];

endmodule
